// File: rtl/li_expander.sv
`default_nettype none
// ============================================================================
// Module   : li_expander
// Function : Converts (rd, 32-bit constant) into the shortest LA32R
//            load-immediate sequence: one word, or lu12i.w followed by ori.
// Revision : 1.0 - initial release
// ============================================================================
module li_expander #(
    parameter logic [31:0] NOP_WORD = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_imm,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic        ins_last,
    output logic        busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_last = 2'd1;
    localparam logic [1:0] c_st_head = 2'd2;

    localparam logic [9:0] c_op_addi  = 10'b0000001010;
    localparam logic [9:0] c_op_ori   = 10'b0000001110;
    localparam logic [6:0] c_op_lu12i = 7'b0001010;

    logic [1:0]  r_state;
    logic [31:0] r_word;
    logic [31:0] r_pending;

    logic        w_accept;
    logic        w_two;
    logic        w_fits_s12;
    logic        w_fits_u12;
    logic        w_low_zero;
    logic [31:0] w_first;
    logic [31:0] w_second;

    // Classification order matters: the signed-12 form wins over ori when both fit.
    always_comb begin
        w_fits_s12 = (req_imm[31:11] == 21'h00_0000) || (req_imm[31:11] == 21'h1F_FFFF);
        w_fits_u12 = (req_imm[31:12] == 20'h0_0000);
        w_low_zero = (req_imm[11:0] == 12'h000);
        w_two      = 1'b0;
        w_second   = 32'h0000_0000;
        if (req_rd == 5'd0) begin
            w_first = NOP_WORD;
        end else if (w_fits_s12) begin
            w_first = {c_op_addi, req_imm[11:0], 5'd0, req_rd};
        end else if (w_fits_u12) begin
            w_first = {c_op_ori, req_imm[11:0], 5'd0, req_rd};
        end else if (w_low_zero) begin
            w_first = {c_op_lu12i, req_imm[31:12], req_rd};
        end else begin
            w_first  = {c_op_lu12i, req_imm[31:12], req_rd};
            w_second = {c_op_ori, req_imm[11:0], req_rd, req_rd};
            w_two    = 1'b1;
        end
    end

    assign req_ready = (r_state == c_st_idle) || ((r_state == c_st_last) && ins_ready);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_st_idle;
            r_word    <= 32'h0000_0000;
            r_pending <= 32'h0000_0000;
        end else begin
            case (r_state)
                c_st_idle, c_st_last: begin
                    // Accept in LAST coincides with the final-word handshake, so no bubble.
                    if (w_accept) begin
                        r_word    <= w_first;
                        r_pending <= w_second;
                        r_state   <= w_two ? c_st_head : c_st_last;
                    end else if ((r_state == c_st_last) && ins_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_head: begin
                    if (ins_ready) begin
                        r_word    <= r_pending;
                        r_pending <= 32'h0000_0000;
                        r_state   <= c_st_last;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ins_valid = (r_state != c_st_idle);
    assign ins_last  = (r_state == c_st_last);
    assign busy      = (r_state != c_st_idle);
    assign ins_word  = r_word;

endmodule
`default_nettype wire

// File: doc/li_expander.md
# li_expander

Load-immediate expander: accepts a destination register and a 32-bit constant, and emits the shortest LA32R instruction sequence that rebuilds that constant in the register. The sequence is one or two words, chosen from addi.w, ori and lu12i.w. It performs the inverse of the immediate-extension unit, which recovers constants from instruction fields. It sits between the boot/self-test sequencer and the instruction-injection port of the fetch stage. Both sides use valid/ready handshakes, and the output is registered.

## Interface
- NOP_WORD, 32'h0340_0000, word emitted alone when rd is r0 (andi r0,r0,0)
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_rd  input  5  destination register
- req_imm  input  32  constant to materialise
- ins_valid  output  1  ins_word valid
- ins_ready  input  1  consumer takes ins_word this cycle
- ins_word  output  32  encoded instruction
- ins_last  output  1  ins_word is final word of its sequence
- busy  output  1  high in any state other than IDLE

## Operation
- Encodings:
  - addi.w = {10'b0000001010, si12, rj, rd}
  - ori = {10'b0000001110, ui12, rj, rd}
  - lu12i.w = {7'b0001010, si20, rd}
  - si12/ui12 occupy bits 21:10, si20 bits 24:5, rj bits 9:5, rd bits 4:0.
- Classification at accept, first match wins:
  - rd==0 → single NOP_WORD.
  - imm[31:11] all zeros or all ones (fits signed 12) → single addi.w rd, r0, imm[11:0].
  - imm[31:12]==0 → single ori rd, r0, imm[11:0].
  - imm[11:0]==0 → single lu12i.w rd, imm[31:12].
  - otherwise → lu12i.w rd, imm[31:12], then ori rd, rd, imm[11:0].
- FSM states:
  - IDLE: output register empty.
  - LAST: output holds a final word.
  - HEAD: output holds lu12i.w, and the ori word is held in a pending register.
- Transitions:
  - IDLE → LAST or HEAD on accept.
  - HEAD → LAST when ins_ready is high; the pending word is loaded into the output.
  - LAST → IDLE when ins_ready is high and no accept occurs.
  - LAST → LAST or HEAD when ins_ready is high and an accept occurs in the same cycle (back-to-back).
- Handshake rules:
  - req_ready = (state==IDLE) | (state==LAST & ins_ready). It is combinational from ins_ready and is never high in HEAD.
  - While ins_valid=1 and ins_ready=0, ins_word, ins_last and state hold stable.
  - ins_valid never drops without a handshake.
- Derived outputs:
  - ins_valid = (state != IDLE).
  - ins_last = (state==LAST).
  - busy = (state != IDLE).
- req_rd and req_imm are sampled only on accept; later changes are ignored.

## Timing
- Reset (resetn low, asynchronous): state=IDLE, ins_valid=0, ins_last=0, busy=0, ins_word=0, pending=0, req_ready=1.
- Reset asserted mid-sequence drops the pending ori word; nothing is emitted after release until a new accept.
- Latency: accept at edge N gives ins_valid at N+1 (registered output, no combinational path from req to ins).
- Throughput with ins_ready held high:
  - single-word requests: 1 word per cycle, sustained;
  - two-word requests: 2 cycles each, with req_ready low during the HEAD cycle.
- A simultaneous final-word handshake and new accept produces no bubble.

## Test plan
- Reset, then req rd=4, imm=0x0000_07FF with ins_ready=1 → one cycle later ins_word=0x029F_FC04, ins_last=1; next cycle ins_valid=0.
- rd=1, imm=0xFFFF_F800 → 0x02A0_0001 (addi.w, negative boundary). rd=2, imm=0x0000_0FFF → 0x03BF_FC02 (ori path).
- rd=5, imm=0x1234_5000 → single 0x1424_68A5, ins_last=1. rd=0, imm=0x1234_5678 → single 0x0340_0000.
- rd=5, imm=0x1234_5678, ins_ready low for 3 cycles after ins_valid rises:
  - 0x1424_68A5 with ins_last=0 holds for all 3 cycles, and req_ready=0 throughout;
  - then 0x0399_E0A5 with ins_last=1.
- Back-to-back stream of 8 single-word requests with ins_ready=1 → 8 consecutive valid words with no gaps. Random ins_ready backpressure → scoreboard matches a reference model exactly.
- Two-word request, assert resetn low while in HEAD → outputs go to reset values immediately. After release, the ori word is never emitted and req_ready=1.
